adc_sample_decoder: RTL and testbench

- Host-side counterpart of the ADC channel-scanning transmitter.
- Consumes the byte stream delivered by a UART receiver and reassembles 12-bit ADC samples.
- Each sample arrives as two bytes: {tag[1:0], val[11:6]} followed by {tag[1:0], val[5:0]}. The tag is the channel number, and channels arrive in order 0,1,2,3,0,...
- Outputs one tagged sample per valid pair and reports framing and sequence errors to downstream logging logic.

---
 rtl/adc_sample_decoder.sv | 181 ++++++++++++++++++
 tb/tb_adc_sample_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_decoder.sv
// Reassembles tagged 12-bit ADC samples from a UART byte stream and tracks
// channel ordering, framing errors and lock status for downstream logging.
module adc_sample_decoder #(
    parameter int TIMEOUT_CYC = 500000,
    parameter int LOCK_PAIRS  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset_N,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             sample_valid,
    output logic [1:0]       sample_ch,
    output logic [11:0]      sample_val,
    output logic             frame_err,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RUN_W = $clog2(LOCK_PAIRS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_PAIRS);

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return ch + 2'd1;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       hi_tag_q, hi_tag_d;
    logic [5:0]       hi_bits_q, hi_bits_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       exp_q, exp_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             locked_q, locked_d;
    logic             sample_valid_q, sample_valid_d;
    logic [1:0]       sample_ch_q, sample_ch_d;
    logic [11:0]      sample_val_q, sample_val_d;
    logic             frame_err_q, frame_err_d;
    logic             seq_err_q, seq_err_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             emit_s;

    // Next-state logic: byte pairing, timeout, sequence tracking, error count.
    always_comb begin
        state_d        = state_q;
        hi_tag_d       = hi_tag_q;
        hi_bits_d      = hi_bits_q;
        tmo_d          = tmo_q;
        exp_d          = exp_q;
        run_d          = run_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_val_d   = sample_val_q;
        frame_err_d    = 1'b0;
        seq_err_d      = 1'b0;
        err_d          = err_q;
        emit_s         = 1'b0;

        case (state_q)
            WAIT_HI: begin
                if (rx_valid) begin
                    hi_tag_d  = rx_data[7:6];
                    hi_bits_d = rx_data[5:0];
                    tmo_d     = '0;
                    state_d   = WAIT_LO;
                end else begin
                    tmo_d = tmo_q;
                end
            end
            WAIT_LO: begin
                // An arriving byte always wins over a timeout in the same cycle.
                if (rx_valid) begin
                    if (rx_data[7:6] == hi_tag_q) begin
                        emit_s         = 1'b1;
                        sample_valid_d = 1'b1;
                        sample_ch_d    = hi_tag_q;
                        sample_val_d   = {hi_bits_q, rx_data[5:0]};
                        state_d        = WAIT_HI;
                    end else begin
                        frame_err_d = 1'b1;
                        hi_tag_d    = rx_data[7:6];
                        hi_bits_d   = rx_data[5:0];
                        tmo_d       = '0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    frame_err_d = 1'b1;
                    hi_tag_d    = 2'd0;
                    hi_bits_d   = 6'd0;
                    tmo_d       = '0;
                    state_d     = WAIT_HI;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = WAIT_HI;
            end
        endcase

        if (emit_s) begin
            if (hi_tag_q == exp_q) begin
                if (run_q != RUN_MAX) begin
                    run_d = run_q + RUN_W'(1);
                end else begin
                    run_d = run_q;
                end
            end else if (locked_q) begin
                seq_err_d = 1'b1;
                run_d     = '0;
            end else begin
                run_d = RUN_W'(1);
            end
            exp_d = next_ch(hi_tag_q);
        end else begin
            exp_d = exp_q;
        end

        if (frame_err_d) begin
            run_d = '0;
        end else begin
            run_d = run_d;
        end

        locked_d = (run_d == RUN_MAX);

        if ((frame_err_d || seq_err_d) && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q        <= WAIT_HI;
            hi_tag_q       <= 2'd0;
            hi_bits_q      <= 6'd0;
            tmo_q          <= '0;
            exp_q          <= 2'd0;
            run_q          <= '0;
            locked_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= 2'd0;
            sample_val_q   <= 12'd0;
            frame_err_q    <= 1'b0;
            seq_err_q      <= 1'b0;
            err_q          <= '0;
        end else begin
            state_q        <= state_d;
            hi_tag_q       <= hi_tag_d;
            hi_bits_q      <= hi_bits_d;
            tmo_q          <= tmo_d;
            exp_q          <= exp_d;
            run_q          <= run_d;
            locked_q       <= locked_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_val_q   <= sample_val_d;
            frame_err_q    <= frame_err_d;
            seq_err_q      <= seq_err_d;
            err_q          <= err_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_val   = sample_val_q;
    assign frame_err    = frame_err_q;
    assign seq_err      = seq_err_q;
    assign locked       = locked_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_adc_sample_decoder.sv
// Self-checking bench: directed scenarios plus randomized byte streams,
// compared every cycle against a pair-level behavioural model.
module tb_adc_sample_decoder;

    localparam int TMO   = 16;
    localparam int LOCK  = 4;
    localparam int EW    = 3;
    localparam int EMAX  = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          reset_N = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          sample_valid;
    logic [1:0]    sample_ch;
    logic [11:0]   sample_val;
    logic          frame_err;
    logic          seq_err;
    logic          locked;
    logic [EW-1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: a pending high byte with its idle age.
    bit         have_hi;
    logic [7:0] hi;
    int         age, exp_ch, run, m_ch, m_val, m_err;
    bit         m_sv, m_fe, m_se, m_lk;

    adc_sample_decoder #(.TIMEOUT_CYC(TMO), .LOCK_PAIRS(LOCK), .ERR_W(EW)) dut (
        .clk(clk), .reset_N(reset_N), .rx_data(rx_data), .rx_valid(rx_valid),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_val(sample_val),
        .frame_err(frame_err), .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("sample_valid", 32'(sample_valid), 32'(m_sv));
        check_eq("sample_ch", 32'(sample_ch), 32'(m_ch));
        check_eq("sample_val", 32'(sample_val), 32'(m_val));
        check_eq("frame_err", 32'(frame_err), 32'(m_fe));
        check_eq("seq_err", 32'(seq_err), 32'(m_se));
        check_eq("locked", 32'(locked), 32'(m_lk));
        check_eq("err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic model_reset();
        have_hi = 1'b0; hi = 8'h00; age = 0; exp_ch = 0; run = 0;
        m_ch = 0; m_val = 0; m_err = 0;
        m_sv = 1'b0; m_fe = 1'b0; m_se = 1'b0; m_lk = 1'b0;
    endtask

    task automatic model_cycle(input bit v, input logic [7:0] d);
        m_sv = 1'b0; m_fe = 1'b0; m_se = 1'b0;
        if (v) begin
            if (!have_hi) begin
                have_hi = 1'b1; hi = d; age = 0;
            end else if (d[7:6] == hi[7:6]) begin
                m_sv = 1'b1;
                m_ch = int'(hi[7:6]);
                m_val = int'(hi[5:0]) * 64 + int'(d[5:0]);
                have_hi = 1'b0;
            end else begin
                m_fe = 1'b1; hi = d; age = 0;
            end
        end else if (have_hi) begin
            age++;
            if (age == TMO) begin
                m_fe = 1'b1; have_hi = 1'b0;
            end
        end
        if (m_sv) begin
            if (m_ch == exp_ch) run = (run < LOCK) ? run + 1 : LOCK;
            else if (m_lk) begin m_se = 1'b1; run = 0; end
            else run = 1;
            exp_ch = (m_ch + 1) % 4;
        end
        if (m_fe) run = 0;
        m_lk = (run >= LOCK);
        if ((m_fe || m_se) && m_err < EMAX) m_err++;
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        model_cycle(v, d);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00);
    endtask

    task automatic send_pair(input logic [1:0] c, input logic [11:0] v, input int gap);
        step(1'b1, {c, v[11:6]});
        idle(gap);
        step(1'b1, {c, v[5:0]});
    endtask

    task automatic apply_reset();
        reset_N  = 1'b0;
        rx_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_N = 1'b1;
    endtask

    initial begin
        logic [1:0]  c, nc;
        logic [7:0]  b;
        logic [11:0] v;
        int          r;

        model_reset();
        #2;
        apply_reset();

        // Clean pair
        step(1'b1, 8'h2A);
        step(1'b1, 8'h15);
        check_eq("clean_val", 32'(sample_val), 32'h0A95);
        check_eq("clean_valid", 32'(sample_valid), 32'd1);
        idle(2);

        // Full scan, lock on the fourth in-order pair, wrap 3 -> 0
        apply_reset();
        step(1'b1, 8'h3F); step(1'b1, 8'h3F);
        check_eq("scan0_val", 32'(sample_val), 32'h0FFF);
        step(1'b1, 8'h40); step(1'b1, 8'h41);
        check_eq("scan1_val", 32'(sample_val), 32'h0001);
        step(1'b1, 8'hBF); step(1'b1, 8'h80);
        check_eq("scan2_val", 32'(sample_val), 32'h0FC0);
        check_eq("scan2_unlocked", 32'(locked), 32'd0);
        step(1'b1, 8'hC0); step(1'b1, 8'hC0);
        check_eq("scan3_val", 32'(sample_val), 32'h0000);
        check_eq("scan3_locked", 32'(locked), 32'd1);
        step(1'b1, 8'h00); step(1'b1, 8'h00);
        check_eq("wrap_ch", 32'(sample_ch), 32'd0);

        // Sequence skip while locked
        step(1'b1, 8'h80); step(1'b1, 8'h80);
        check_eq("skip_seq_err", 32'(seq_err), 32'd1);
        check_eq("skip_valid", 32'(sample_valid), 32'd1);
        check_eq("skip_unlocked", 32'(locked), 32'd0);
        send_pair(2'd3, 12'h123, 0);
        idle(1);

        // Lost low byte
        apply_reset();
        step(1'b1, 8'h2A);
        step(1'b1, 8'h41);
        check_eq("lost_frame_err", 32'(frame_err), 32'd1);
        step(1'b1, 8'h42);
        check_eq("lost_val", 32'(sample_val), 32'h0042);
        check_eq("lost_ch", 32'(sample_ch), 32'd1);
        check_eq("lost_err_count", 32'(err_count), 32'd1);

        // Timeout fires on the TMO-th idle cycle
        apply_reset();
        step(1'b1, 8'h2A);
        idle(TMO - 1);
        check_eq("tmo_not_yet", 32'(frame_err), 32'd0);
        idle(1);
        check_eq("tmo_frame_err", 32'(frame_err), 32'd1);
        step(1'b1, 8'h01); step(1'b1, 8'h02);
        check_eq("tmo_after_val", 32'(sample_val), 32'h0042);
        // Low byte in the expiry cycle wins over the timeout
        step(1'b1, 8'h6A);
        idle(TMO - 1);
        step(1'b1, 8'h55);
        check_eq("tmo_race_valid", 32'(sample_valid), 32'd1);
        check_eq("tmo_race_fe", 32'(frame_err), 32'd0);

        // Error counter saturation, then reset mid-pair
        apply_reset();
        step(1'b1, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            b = {2'(k % 4), 6'h00};
            step(1'b1, b);
        end
        check_eq("sat_err_count", 32'(err_count), 32'(EMAX));
        step(1'b1, 8'h2A);
        apply_reset();
        step(1'b1, 8'h15); step(1'b1, 8'h2A);
        check_eq("rst_pair_val", 32'(sample_val), 32'h056A);

        // Randomized traffic
        nc = 2'd1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 12) begin
                c = (r < 10) ? nc : 2'($urandom_range(0, 3));
                v = 12'($urandom_range(0, 4095));
                send_pair(c, v, $urandom_range(0, 3));
                nc = c + 2'd1;
            end else if (r < 15) begin
                b = 8'($urandom_range(0, 255));
                step(1'b1, b);
            end else if (r < 17) begin
                b = 8'($urandom_range(0, 255));
                step(1'b1, b);
                idle(TMO - 2 + $urandom_range(0, 4));
            end else if (r < 19) begin
                idle($urandom_range(1, 5));
            end else begin
                apply_reset();
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
